// File: rtl/apb_rr_master.sv
// Two-requester APB3 master: round-robin arbitration between two command ports,
// one SETUP/ACCESS transfer per accepted command, response routed back to its issuer.
module apb_rr_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                pclk,
  input  logic                presetn,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [1:0]          req_write,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [2*DATA_W-1:0] req_wdata,
  output logic [1:0]          rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                psel,
  output logic                penable,
  output logic                pwrite,
  output logic [ADDR_W-1:0]   paddr,
  output logic [DATA_W-1:0]   pwdata,
  input  logic                pready,
  input  logic                pslverr,
  input  logic [DATA_W-1:0]   prdata
);

  localparam int CNT_W = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t              state_q, state_d;
  logic                psel_q, psel_d;
  logic                penable_q, penable_d;
  logic                pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic                id_q, id_d;
  logic                last_q, last_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [1:0]          rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;

  logic                win_id;
  logic                accept;

  // Requester 1 wins when it is alone, or when both ask and requester 0 was served last.
  always_comb begin
    win_id    = req_valid[1] & (~req_valid[0] | ~last_q);
    req_ready = 2'b00;
    if (state_q == IDLE && req_valid != 2'b00) begin
      req_ready = win_id ? 2'b10 : 2'b01;
    end
    accept = |(req_valid & req_ready);
  end

  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    id_d        = id_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    rsp_valid_d = 2'b00;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d   = SETUP;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          pwrite_d  = req_write[win_id];
          paddr_d   = win_id ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
          pwdata_d  = win_id ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
          id_d      = win_id;
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
        cnt_d     = '0;
      end
      ACCESS: begin
        if (pready) begin
          state_d     = RESP;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = id_q ? 2'b10 : 2'b01;
          rsp_rdata_d = pwrite_q ? '0 : prdata;
          rsp_err_d   = pslverr;
        end else if (cnt_q == CNT_LAST) begin
          // Slave never answered: release the bus and report an error.
          state_d     = RESP;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = id_q ? 2'b10 : 2'b01;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
        last_d  = id_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q     <= IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      id_q        <= 1'b0;
      last_q      <= 1'b1;
      cnt_q       <= '0;
      rsp_valid_q <= 2'b00;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      id_q        <= id_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_rr_master.sv
// Bench for apb_rr_master: APB slave with a small memory, randomized commands
// checked against a transaction-level memory/arbitration model.
module tb_apb_rr_master;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          pclk = 1'b0;
  logic          presetn;
  logic [1:0]    req_valid;
  logic [1:0]    req_ready;
  logic [1:0]    req_write;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic [1:0]    rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          psel, penable, pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic          pready, pslverr;
  logic [DW-1:0] prdata;

  apb_rr_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .pclk(pclk), .presetn(presetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata),
    .pready(pready), .pslverr(pslverr), .prdata(prdata)
  );

  always #5 pclk = ~pclk;

  // Slave: answers after wait_n wait states, errors on address 0x20, or never answers when hung.
  int          wait_n = 0;
  bit          hang   = 0;
  int          acc_cnt = 0;
  logic [31:0] mem [0:15] = '{default: 32'h0};

  always_comb begin
    pready  = psel && penable && !hang && (acc_cnt == wait_n);
    pslverr = (paddr == 32'h20);
    prdata  = mem[paddr[5:2]];
  end

  always @(posedge pclk) begin
    if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
    if (psel && penable && pready && pwrite && !pslverr) mem[paddr[5:2]] <= pwdata;
  end

  // Reference model state
  logic [31:0] ref_mem [0:15] = '{default: 32'h0};
  int          last_served = 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_xfer(input int id, input bit wr, input logic [31:0] addr,
                         input logic [31:0] wd, input int waits);
    logic [31:0] exp_rd;
    bit          exp_err, got, stable;
    int          exp_lat, exp_acc, n, acc;
    wait_n  = waits;
    exp_err = hang || (addr == 32'h20);
    exp_rd  = (hang || wr) ? 32'h0 : ref_mem[addr[5:2]];
    exp_lat = hang ? TO + 2 : 3 + waits;
    exp_acc = hang ? TO : waits + 1;
    @(negedge pclk);
    req_valid[id] = 1'b1;
    req_write[id] = wr;
    req_addr[id*AW +: AW]  = addr;
    req_wdata[id*DW +: DW] = wd;
    got = 0;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (req_ready == (2'b01 << id)) begin
        got = 1;
        break;
      end
      @(negedge pclk);
    end
    chk("grant", {63'h0, got}, 64'h1);
    if (!got) begin
      req_valid[id] = 1'b0;
      return;
    end
    @(negedge pclk);
    req_valid[id] = 1'b0;
    n = 1;
    acc = 0;
    stable = 1;
    while (rsp_valid == 2'b00 && n < 60) begin
      if (psel) stable &= (paddr == addr) && (pwrite == wr) && (!wr || pwdata == wd);
      else stable = 0;
      if (n == 1) stable &= !penable;
      if (psel && penable) acc++;
      @(negedge pclk);
      n++;
    end
    chk("latency", n, exp_lat);
    chk("bus_stable", {63'h0, stable}, 64'h1);
    chk("access_cycles", acc, exp_acc);
    chk("rsp_id", rsp_valid, 2'b01 << id);
    chk("rsp_rdata", rsp_rdata, exp_rd);
    chk("rsp_err", rsp_err, exp_err);
    chk("psel_idle_in_resp", {psel, penable}, 2'b00);
    if (wr && !exp_err) ref_mem[addr[5:2]] = wd;
    last_served = id;
    @(negedge pclk);
    chk("rsp_strobe_one_cycle", rsp_valid, 2'b00);
  endtask

  initial begin
    int grants, rsps, last_g, exp_id;
    int q[$];
    bit got;
    presetn   = 1'b0;
    req_valid = 2'b00;
    req_write = 2'b00;
    req_addr  = '0;
    req_wdata = '0;
    #12;
    chk("rst_apb_ctl", {psel, penable, pwrite}, 3'b000);
    chk("rst_paddr", paddr, 0);
    chk("rst_pwdata", pwdata, 0);
    chk("rst_rsp", {rsp_valid, rsp_err}, 3'b000);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_ready", req_ready, 2'b00);
    @(negedge pclk);
    presetn = 1'b1;

    // Directed: zero-wait write/read, wait states, slave error, recovery
    do_xfer(0, 1, 32'h0, 32'h12345678, 0);
    do_xfer(0, 0, 32'h0, 32'h0, 0);
    do_xfer(1, 1, 32'h10, 32'hCAFEF00D, 3);
    do_xfer(0, 0, 32'h10, 32'h0, 3);
    do_xfer(1, 0, 32'h20, 32'h0, 1);
    do_xfer(1, 0, 32'h4, 32'h0, 0);

    // Randomized mix
    for (int i = 0; i < 24; i++) begin
      do_xfer($urandom_range(0, 1), 1'($urandom_range(0, 1)),
              {26'h0, 4'($urandom_range(0, 15)), 2'b00}, $urandom, $urandom_range(0, 4));
    end

    // Contention: both requesters read continuously
    wait_n = 0;
    @(negedge pclk);
    req_write = 2'b00;
    req_addr  = {32'hC, 32'h8};
    req_valid = 2'b11;
    grants = 0;
    rsps   = 0;
    last_g = 0;
    for (int cyc = 0; cyc < 41; cyc++) begin
      #1;
      if (req_ready != 2'b00) begin
        chk("rr_grant", req_ready, 2'b01 << (1 - last_served));
        if (grants > 0) chk("grant_spacing", cyc - last_g, 4);
        q.push_back(1 - last_served);
        last_g = cyc;
        grants++;
      end
      if (rsp_valid != 2'b00) begin
        exp_id = (q.size() > 0) ? q.pop_front() : 0;
        chk("rr_rsp_id", rsp_valid, 2'b01 << exp_id);
        chk("rr_rdata", rsp_rdata, ref_mem[exp_id ? 3 : 2]);
        last_served = exp_id;
        rsps++;
      end
      @(negedge pclk);
    end
    req_valid = 2'b00;
    chk("rr_grant_count", {63'h0, grants >= 8}, 64'h1);
    chk("rr_no_lost", {63'h0, rsps >= grants - 1}, 64'h1);
    repeat (4) @(negedge pclk);
    last_served = (q.size() > 0) ? q.pop_front() : last_served;

    // Timeout with a hung slave
    hang = 1;
    do_xfer(0, 0, 32'h8, 32'h0, 0);
    hang = 0;

    // Reset during wait states
    wait_n = 10;
    @(negedge pclk);
    req_write[1] = 1'b0;
    req_addr[AW +: AW] = 32'h4;
    req_valid[1] = 1'b1;
    got = 0;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (req_ready[1]) begin
        got = 1;
        break;
      end
      @(negedge pclk);
    end
    chk("rst_test_grant", {63'h0, got}, 64'h1);
    @(negedge pclk);
    req_valid[1] = 1'b0;
    for (int k = 0; k < 10 && !(psel && penable); k++) @(negedge pclk);
    @(negedge pclk);
    chk("in_access_before_rst", {psel, penable}, 2'b11);
    #2 presetn = 1'b0;
    #1;
    chk("async_rst_bus", {psel, penable}, 2'b00);
    chk("async_rst_rsp", rsp_valid, 2'b00);
    @(negedge pclk);
    @(negedge pclk);
    chk("no_rsp_after_abort", rsp_valid, 2'b00);
    presetn = 1'b1;
    last_served = 1;
    do_xfer(1, 0, 32'h4, 32'h0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
